// File: rtl/ifmap_skew_feeder.sv
// ifmap_skew_feeder: buffers ifmap column vectors in a small FIFO and issues
// them into the PE array with a diagonal skew (lane r delayed r cycles).
// It pulses done_o once the final lane of a tile's last vector has been issued.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid_i    vector valid            in_ready_o  FIFO not full (combinational)
//   in_data_i     ROWS lanes of DATA_WIDTH, lane r at [r*DATA_WIDTH +: DATA_WIDTH]
//   in_last_i     final vector of a tile
//   stall_i       freezes issue, FSM and skew pipeline; gates ifmap_en_o low
//   ifmap_o       skewed lane data per PE row
//   ifmap_en_o    per-row ifmap enable
//   done_o        one-cycle tile-complete pulse
module ifmap_skew_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data_i,
  input  logic                       in_last_i,
  input  logic                       stall_i,
  output logic [ROWS*DATA_WIDTH-1:0] ifmap_o,
  output logic [ROWS-1:0]            ifmap_en_o,
  output logic                       done_o
);

  localparam int unsigned VEC_W = ROWS * DATA_WIDTH;
  localparam int unsigned ENT_W = VEC_W + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DC_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;
  logic [ENT_W-1:0] head;
  logic [VEC_W-1:0] head_data;
  logic             head_last;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign in_ready_o = ~full;
  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign push       = in_valid_i & ~full;
  assign head       = mem[rd_ptr];
  assign head_data  = head[VEC_W-1:0];
  assign head_last  = head[VEC_W];

  // Storage array, no reset needed: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last_i, in_data_i};
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t           state_q, state_d;
  logic [DC_W-1:0]  drain_q, drain_d;
  logic             done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= (state_d == DONE);
    end
  end

  // Next state and pop; the drain counter waits for the last lane to issue.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pop     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!empty && !stall_i) begin
          pop = 1'b1;
          if (head_last) begin
            state_d = DRAIN;
            drain_d = DC_W'(ROWS - 1);
          end
        end
      end
      DRAIN: begin
        if (!stall_i) begin
          if (drain_q == '0) state_d = DONE;
          else               drain_d = drain_q - DC_W'(1);
        end
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign done_o = done_q;

  // ------------------------------------------------------- skew pipeline
  // Lane r is a chain of r+1 stages; data regs load only behind a valid bit.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    for (genvar k = 0; k <= r; k++) begin : g_stage
      logic                  in_v;
      logic [DATA_WIDTH-1:0] in_d;
      logic                  v_q;
      logic [DATA_WIDTH-1:0] d_q;

      if (k == 0) begin : g_head
        assign in_v = pop;
        assign in_d = head_data[r*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_link
        assign in_v = g_stage[k-1].v_q;
        assign in_d = g_stage[k-1].d_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else if (!stall_i) begin
          v_q <= in_v;
          if (in_v) d_q <= in_d;
        end
      end
    end

    // Gating every row with stall keeps the wavefront aligned across rows.
    assign ifmap_o[r*DATA_WIDTH +: DATA_WIDTH] = g_stage[r].d_q;
    assign ifmap_en_o[r]                       = g_stage[r].v_q & ~stall_i;
  end

endmodule
